if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the 64-bit PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Each cycle it presents one instruction and its address, or the flush NOP, to the IF/ID register.
- Handles jump redirects, pipeline stalls, and buffering of a response that arrives during a stall.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0001, instruction word driven when no valid instruction is presented (pipeline flush value).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- jump_en_i  in  1  redirect request from execute/branch logic.
- jump_addr_i  in  64  redirect target; bits [1:0] ignored, treated as 0.
- pipe_hold_en_i  in  3  pipeline hold code; stall = (pipe_hold_en_i != 3'b000).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  64  fetch address; equals PC.
- imem_gnt_i  in  1  request accepted in a cycle where imem_req_o & imem_gnt_i.
- imem_rvalid_i  in  1  response valid; at least 1 cycle after the accepting cycle.
- imem_rdata_i  in  32  response instruction word.
- inst_o  out  32  instruction to IF/ID.
- inst_addr_o  out  64  address of inst_o.
- inst_valid_o  out  1  inst_o is a real fetched instruction.

Behaviour:
- Registers: pc[63:0], fetch_addr[63:0], buf_inst[31:0], kill flag, state in {S_REQ, S_WAIT, S_HOLD}.
- Reset (rst_n=0 at a clock edge): pc=RESET_PC, state=S_REQ, kill=0, buf_inst=NOP_INST, fetch_addr=0.
- While rst_n=0, outputs are forced: imem_req_o=0, inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0.
- Reset mid-transaction abandons any outstanding request. A late rvalid after reset, arriving in S_REQ, is ignored.
- Default outputs (every case not listed below): inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0, imem_addr_o=pc.
- Priority within each state: jump_en_i over response handling over stall.
- PC arithmetic: pc+4 wraps modulo 2^64. Jump loads {jump_addr_i[63:2],2'b00}.
- S_REQ:
  - imem_req_o = !stall & !jump_en_i.
  - jump_en_i: pc<=target; stay S_REQ; no request issued this cycle.
  - req & gnt: fetch_addr<=pc; pc<=pc+4; go S_WAIT.
  - req & !gnt: hold pc; retry next cycle (address stable).
  - stall: no request; stay.
- S_WAIT (imem_req_o=0):
  - jump_en_i without rvalid: pc<=target; kill<=1; stay.
  - rvalid & (kill | jump_en_i): discard the word; if jump_en_i, pc<=target; kill<=0; go S_REQ; outputs default.
  - rvalid & !kill & !stall: inst_o=imem_rdata_i, inst_addr_o=fetch_addr, inst_valid_o=1 (combinational, same cycle); go S_REQ.
  - rvalid & !kill & stall: buf_inst<=imem_rdata_i; go S_HOLD; outputs default.
- S_HOLD (imem_req_o=0):
  - jump_en_i: drop buffer; pc<=target; go S_REQ.
  - !stall: inst_o=buf_inst, inst_addr_o=fetch_addr, inst_valid_o=1; go S_REQ.
  - stall: stay; outputs default.
- Only one request is ever outstanding. With a 1-cycle memory, peak throughput is one instruction per 2 cycles.
- Latency from accepted request to inst_o is the memory latency (same cycle as rvalid when not stalled).
- No instruction is presented twice. No instruction from a killed path is ever presented.

Test Plan:
- Reset then free-run with 1-cycle memory returning addr[31:0] as data:
  - requests at 0x80000000, 0x80000004, 0x80000008.
  - inst_o valid with matching inst_addr_o every 2nd cycle.
- Hold gnt=0 for 3 cycles at pc 0x80000000: imem_req_o stays 1 with a stable address; pc advances only after gnt.
- Assert stall in the rvalid cycle for word 0x00A00093 at 0x80000004:
  - NOP/valid 0 while stalled.
  - On stall release, inst_o=0x00A00093, inst_addr_o=0x80000004, valid=1 for one cycle.
- jump_en_i to 0x80001002 while in S_WAIT:
  - the returning word is discarded (valid stays 0).
  - next request address is 0x80001000.
- jump_en_i during S_HOLD: buffered word never presented; next request at the jump target.
- Edge cases:
  - pc=0xFFFFFFFFFFFFFFFC fetch: next pc wraps to 0.
  - rst_n=0 asserted during S_WAIT: outputs NOP/0 and the next request goes to RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// keeps at most one request outstanding to instruction memory
// (req/gnt/rvalid), and each cycle presents either one fetched instruction
// with its address or the flush NOP.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   jump_en_i       redirect request
//   jump_addr_i     redirect target (bits [1:0] ignored)
//   pipe_hold_en_i  hold code; any non-zero value stalls the pipeline
//   imem_req_o      fetch request
//   imem_addr_o     fetch address (current PC)
//   imem_gnt_i      request accepted when imem_req_o & imem_gnt_i
//   imem_rvalid_i   response valid
//   imem_rdata_i    response instruction word
//   inst_o          instruction to IF/ID
//   inst_addr_o     address of inst_o
//   inst_valid_o    inst_o is a real fetched instruction
//
// States
//   state  | meaning
//   S_REQ  | issuing (or retrying) a request at pc
//   S_WAIT | request accepted, waiting for rvalid
//   S_HOLD | response captured in buf_inst while the pipeline is stalled
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [63:0] jump_addr_i,
    input  logic [2:0]  pipe_hold_en_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] fetch_addr, fetch_addr_nxt;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic        kill, kill_nxt;

    logic        stall;
    logic [63:0] jump_tgt;
    logic [63:0] pc_inc;
    logic        unused_jump_lsb;

    assign stall           = (pipe_hold_en_i != 3'b000);
    assign jump_tgt        = {jump_addr_i[63:2], 2'b00};
    assign pc_inc          = pc + 64'd4;
    assign unused_jump_lsb = ^jump_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            fetch_addr <= 64'd0;
            buf_inst   <= NOP_INST;
            kill       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fetch_addr <= fetch_addr_nxt;
            buf_inst   <= buf_inst_nxt;
            kill       <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        fetch_addr_nxt = fetch_addr;
        buf_inst_nxt   = buf_inst;
        kill_nxt       = kill;

        imem_req_o     = 1'b0;
        imem_addr_o    = pc;
        inst_o         = NOP_INST;
        inst_addr_o    = 64'd0;
        inst_valid_o   = 1'b0;

        case (state)
            S_REQ: begin
                // A late rvalid left over from before a reset lands here and
                // is ignored by construction.
                imem_req_o = !stall && !jump_en_i;
                if (jump_en_i) begin
                    pc_nxt = jump_tgt;
                end else if (imem_req_o && imem_gnt_i) begin
                    fetch_addr_nxt = pc;
                    pc_nxt         = pc_inc;
                    state_nxt      = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill || jump_en_i) begin
                        // Word belongs to an abandoned path.
                        if (jump_en_i) begin
                            pc_nxt = jump_tgt;
                        end
                        kill_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else if (!stall) begin
                        inst_o       = imem_rdata_i;
                        inst_addr_o  = fetch_addr;
                        inst_valid_o = 1'b1;
                        state_nxt    = S_REQ;
                    end else begin
                        buf_inst_nxt = imem_rdata_i;
                        state_nxt    = S_HOLD;
                    end
                end else if (jump_en_i) begin
                    // Response still in flight: remember to drop it.
                    pc_nxt   = jump_tgt;
                    kill_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                if (jump_en_i) begin
                    pc_nxt    = jump_tgt;
                    state_nxt = S_REQ;
                end else if (!stall) begin
                    inst_o       = buf_inst;
                    inst_addr_o  = fetch_addr;
                    inst_valid_o = 1'b1;
                    state_nxt    = S_REQ;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase

        if (!rst_n) begin
            imem_req_o   = 1'b0;
            inst_o       = NOP_INST;
            inst_addr_o  = 64'd0;
            inst_valid_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0001;

    logic        clk;
    logic        rst_n;
    logic        jump_en_i;
    logic [63:0] jump_addr_i;
    logic [2:0]  pipe_hold_en_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_o;
    logic        inst_valid_o;

    if_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump_en_i      (jump_en_i),
        .jump_addr_i    (jump_addr_i),
        .pipe_hold_en_i (pipe_hold_en_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .inst_valid_o   (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
    } out_t;

    out_t        out_q[$];
    logic [63:0] req_q[$];

    int checks   = 0;
    int failures = 0;

    // memory model controls
    int          mem_lat  = 1;
    logic        ovr_en   = 1'b0;
    logic [63:0] ovr_addr = 64'd0;
    logic [31:0] ovr_data = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_out(input logic [63:0] a, input logic [31:0] d);
        out_t e;
        e.addr = a;
        e.inst = d;
        out_q.push_back(e);
    endtask

    // Instruction memory: accepts at negedge, answers mem_lat cycles later.
    initial begin
        logic        pend;
        int          left;
        logic [31:0] pd;
        pend          = 1'b0;
        left          = 0;
        pd            = 32'd0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        forever begin
            @(negedge clk);
            if (imem_req_o && imem_gnt_i) begin
                pend = 1'b1;
                left = mem_lat;
                pd   = (ovr_en && imem_addr_o == ovr_addr) ? ovr_data : imem_addr_o[31:0];
            end
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            if (pend) begin
                left--;
                if (left == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = pd;
                    pend          = 1'b0;
                end
            end
        end
    end

    // Request monitor
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req_o && imem_gnt_i) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got addr %h expected no request", imem_addr_o);
                end else begin
                    chk("req_addr", imem_addr_o, req_q.pop_front());
                end
            end
        end
    end

    // Output monitor
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (inst_valid_o) begin
                if (out_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst: got inst %h addr %h expected no valid", inst_o, inst_addr_o);
                end else begin
                    e = out_q.pop_front();
                    chk("inst_addr", inst_addr_o, e.addr);
                    chk("inst_data", 64'(inst_o), 64'(e.inst));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        jump_en_i      = 1'b0;
        jump_addr_i    = 64'd0;
        pipe_hold_en_i = 3'b000;
        imem_gnt_i     = 1'b1;

        // reset state
        tick(2);
        @(negedge clk);
        chk("rst_req", 64'(imem_req_o), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'(NOP_INST));
        chk("rst_inst_addr", inst_addr_o, 64'd0);
        chk("rst_valid", 64'(inst_valid_o), 64'd0);
        chk("rst_pc", imem_addr_o, RESET_PC);
        tick(1);

        // free run, 1-cycle memory
        req_q.push_back(64'h8000_0000);
        req_q.push_back(64'h8000_0004);
        req_q.push_back(64'h8000_0008);
        push_out(64'h8000_0000, 32'h8000_0000);
        push_out(64'h8000_0004, 32'h8000_0004);
        push_out(64'h8000_0008, 32'h8000_0008);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("run_valid_cadence", 64'(inst_valid_o), (i % 2 == 1) ? 64'd1 : 64'd0);
            tick(1);
        end
        imem_gnt_i = 1'b0;
        rst_n      = 1'b0;
        tick(2);

        // grant withheld for 3 cycles
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nognt_req", 64'(imem_req_o), 64'd1);
            chk("nognt_addr", imem_addr_o, RESET_PC);
            tick(1);
        end
        imem_gnt_i = 1'b1;
        req_q.push_back(64'h8000_0000);
        push_out(64'h8000_0000, 32'h8000_0000);
        tick(1);
        @(negedge clk);
        chk("gnt_pc_adv", imem_addr_o, 64'h8000_0004);
        tick(1);

        // stall in the rvalid cycle
        ovr_en   = 1'b1;
        ovr_addr = 64'h8000_0004;
        ovr_data = 32'h00A0_0093;
        req_q.push_back(64'h8000_0004);
        tick(1);
        pipe_hold_en_i = 3'b010;
        imem_gnt_i     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(inst_valid_o), 64'd0);
            chk("stall_inst", 64'(inst_o), 64'(NOP_INST));
            tick(1);
        end
        push_out(64'h8000_0004, 32'h00A0_0093);
        pipe_hold_en_i = 3'b000;
        tick(1);

        // jump while waiting (2-cycle memory, word discarded)
        mem_lat    = 2;
        imem_gnt_i = 1'b1;
        req_q.push_back(64'h8000_0008);
        req_q.push_back(64'h8000_1000);
        tick(1);
        imem_gnt_i  = 1'b0;
        jump_en_i   = 1'b1;
        jump_addr_i = 64'h8000_1002;
        tick(1);
        jump_en_i = 1'b0;
        tick(1);
        imem_gnt_i = 1'b1;
        push_out(64'h8000_1000, 32'h8000_1000);
        tick(1);
        imem_gnt_i = 1'b0;
        tick(2);

        // jump while holding a buffered word
        mem_lat    = 1;
        imem_gnt_i = 1'b1;
        req_q.push_back(64'h8000_1004);
        req_q.push_back(64'h8000_2000);
        tick(1);
        pipe_hold_en_i = 3'b100;
        imem_gnt_i     = 1'b0;
        tick(1);
        jump_en_i   = 1'b1;
        jump_addr_i = 64'h8000_2000;
        tick(1);
        jump_en_i      = 1'b0;
        pipe_hold_en_i = 3'b000;
        imem_gnt_i     = 1'b1;
        push_out(64'h8000_2000, 32'h8000_2000);
        tick(1);
        imem_gnt_i = 1'b0;
        tick(1);

        // PC wrap at the top of the address space
        jump_en_i   = 1'b1;
        jump_addr_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(1);
        jump_en_i  = 1'b0;
        imem_gnt_i = 1'b1;
        req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        push_out(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC);
        tick(1);
        imem_gnt_i = 1'b0;
        @(negedge clk);
        chk("wrap_pc", imem_addr_o, 64'd0);
        tick(1);

        // reset during S_WAIT, late rvalid must be ignored
        mem_lat    = 2;
        imem_gnt_i = 1'b1;
        req_q.push_back(64'd0);
        tick(1);
        imem_gnt_i = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk("midrst_req", 64'(imem_req_o), 64'd0);
        chk("midrst_inst", 64'(inst_o), 64'(NOP_INST));
        chk("midrst_inst_addr", inst_addr_o, 64'd0);
        chk("midrst_valid", 64'(inst_valid_o), 64'd0);
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_req", 64'(imem_req_o), 64'd1);
        chk("postrst_addr", imem_addr_o, RESET_PC);
        tick(1);
        imem_gnt_i = 1'b1;
        req_q.push_back(64'h8000_0000);
        push_out(64'h8000_0000, 32'h8000_0000);
        tick(1);
        imem_gnt_i = 1'b0;

        for (int i = 0; i < 20 && (out_q.size() != 0 || req_q.size() != 0); i++) begin
            tick(1);
        end
        tick(3);
        chk("out_q_drained", 64'(out_q.size()), 64'd0);
        chk("req_q_drained", 64'(req_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
